// File: rtl/bloke2b_block_packer.sv
// Byte-stream framer for BLAKE2b/2s: packs bytes little-endian into 16-word blocks and tracks the byte counter t.
// Optional keyed mode (key block 0) is enabled with `define BLOKE2B_PACKER_KEY_EN.
module bloke2b_block_packer #(
    parameter int W     = 64,
    parameter int CNT_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               finish,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [16*W-1:0]    blk_data,
    output logic [CNT_W-1:0]   blk_cnt,
    output logic               blk_last,
    output logic               blk_valid,
    input  logic               blk_ready
`ifdef BLOKE2B_PACKER_KEY_EN
    ,
    input  logic [6:0]         key_len
`endif
);

    localparam int NB    = 2 * W;
    localparam int BW    = 16 * W;
    localparam int IDX_W = $clog2(NB) + 1;
    localparam logic [IDX_W-1:0] NB_IDX = IDX_W'(NB);
    localparam logic [CNT_W-1:0] NB_CNT = CNT_W'(NB);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_HOLD      = 3'd2,
        S_EMIT      = 3'd3,
        S_EMIT_LAST = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t             r_state;
    logic [BW-1:0]      r_buf;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_fin_pend;
    logic [BW-1:0]      r_blk_data;
    logic [CNT_W-1:0]   r_blk_cnt;
    logic               r_blk_last;
    logic               r_blk_valid;

    logic               w_acc;
    logic               w_fin;
    logic               w_key_done;
    logic               w_full;
    logic [IDX_W-1:0]   w_idx_nx;
    logic [CNT_W-1:0]   w_cnt_eff;
    logic [BW-1:0]      w_buf;

    assign din_ready = (r_state == S_FILL) && (r_idx < NB_IDX);
    assign blk_data  = r_blk_data;
    assign blk_cnt   = r_blk_cnt;
    assign blk_last  = r_blk_last;
    assign blk_valid = r_blk_valid;

    assign w_acc    = din_valid && din_ready;
    assign w_fin    = finish || r_fin_pend;
    assign w_idx_nx = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};

`ifdef BLOKE2B_PACKER_KEY_EN
    logic [6:0] r_key_rem;

    // Remaining key bytes; the byte that drains it closes block 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_rem <= 7'd0;
        end else if (start) begin
            r_key_rem <= key_len;
        end else if (w_acc && (r_key_rem != 7'd0)) begin
            r_key_rem <= r_key_rem - 7'd1;
        end
    end

    assign w_key_done = w_acc && (r_key_rem == 7'd1);
`else
    assign w_key_done = 1'b0;
`endif

    assign w_full    = (w_acc && (w_idx_nx == NB_IDX)) || w_key_done;
    assign w_cnt_eff = w_key_done ? NB_CNT :
                       (w_acc ? (r_cnt + {{(CNT_W-1){1'b0}}, 1'b1}) : r_cnt);

    // Buffer image including the byte transferred this cycle.
    always_comb begin
        w_buf = r_buf;
        if (w_acc) begin
            w_buf[{r_idx[IDX_W-2:0], 3'b000} +: 8] = din;
        end else begin
            w_buf = r_buf;
        end
    end

    // Framing FSM with registered block outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_fin_pend  <= 1'b0;
            r_blk_data  <= '0;
            r_blk_cnt   <= '0;
            r_blk_last  <= 1'b0;
            r_blk_valid <= 1'b0;
        end else if (start) begin
            r_state     <= S_FILL;
            r_buf       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_fin_pend  <= 1'b0;
            r_blk_last  <= 1'b0;
            r_blk_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_cnt <= w_cnt_eff;
                    if (w_fin) begin
                        r_blk_data  <= w_buf;
                        r_blk_cnt   <= w_cnt_eff;
                        r_blk_last  <= 1'b1;
                        r_blk_valid <= 1'b1;
                        r_buf       <= '0;
                        r_idx       <= '0;
                        r_fin_pend  <= 1'b0;
                        r_state     <= S_EMIT_LAST;
                    end else if (w_full) begin
                        r_buf   <= w_buf;
                        r_idx   <= NB_IDX;
                        r_state <= S_HOLD;
                    end else begin
                        r_buf <= w_buf;
                        r_idx <= w_acc ? w_idx_nx : r_idx;
                    end
                end
                S_HOLD: begin
                    // A waiting byte proves this block is not the last; it is taken after the handshake.
                    if (din_valid) begin
                        r_blk_data  <= r_buf;
                        r_blk_cnt   <= r_cnt;
                        r_blk_last  <= 1'b0;
                        r_blk_valid <= 1'b1;
                        r_buf       <= '0;
                        r_idx       <= '0;
                        r_fin_pend  <= finish;
                        r_state     <= S_EMIT;
                    end else if (finish) begin
                        r_blk_data  <= r_buf;
                        r_blk_cnt   <= r_cnt;
                        r_blk_last  <= 1'b1;
                        r_blk_valid <= 1'b1;
                        r_buf       <= '0;
                        r_idx       <= '0;
                        r_state     <= S_EMIT_LAST;
                    end
                end
                S_EMIT: begin
                    if (finish) begin
                        r_fin_pend <= 1'b1;
                    end
                    if (blk_ready) begin
                        r_blk_valid <= 1'b0;
                        r_state     <= S_FILL;
                    end
                end
                S_EMIT_LAST: begin
                    if (blk_ready) begin
                        r_blk_valid <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_IDLE, S_DONE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_blk_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bloke2b_block_packer.sv
// Scoreboard bench for bloke2b_block_packer: a byte-level model pushes expected blocks, the consumer pops and compares.
// Keyed scenarios run when BLOKE2B_PACKER_KEY_EN is defined.
module tb_bloke2b_block_packer;

    localparam int W     = 64;
    localparam int CNT_W = 128;
    localparam int NB    = 2 * W;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [16*W-1:0]  data;
        logic [CNT_W-1:0] cnt;
        logic             last;
    } blk_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               finish = 1'b0;
    logic [7:0]         din = 8'd0;
    logic               din_valid = 1'b0;
    logic               din_ready;
    logic [16*W-1:0]    blk_data;
    logic [CNT_W-1:0]   blk_cnt;
    logic               blk_last;
    logic               blk_valid;
    logic               blk_ready = 1'b1;
`ifdef BLOKE2B_PACKER_KEY_EN
    logic [6:0]         key_len = 7'd0;
`endif

    blk_t   sb_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    bit     bp_en = 1'b0;

    bloke2b_block_packer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .finish    (finish),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .blk_data  (blk_data),
        .blk_cnt   (blk_cnt),
        .blk_last  (blk_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready)
`ifdef BLOKE2B_PACKER_KEY_EN
        ,
        .key_len   (key_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_block(input string tag, input blk_t e);
        for (int q = 0; q < 4; q++) begin
            check_value({tag, "_data"}, blk_data[256*q +: 256], e.data[256*q +: 256]);
        end
        check_value({tag, "_cnt"}, 256'(blk_cnt), 256'(e.cnt));
        check_value({tag, "_last"}, 256'(blk_last), 256'(e.last));
    endtask

    // Byte-level reference: key block (if any), then the message cut into 2W-byte chunks.
    task automatic expect_msg(input bq_t key, input bq_t msg);
        blk_t b;
        int   base = 0;
        int   len  = msg.size();
        int   nblk = (len + NB - 1) / NB;
        if (key.size() > 0) begin
            b.data = '0;
            for (int i = 0; i < key.size(); i++) b.data[8*i +: 8] = key[i];
            b.cnt  = CNT_W'(NB);
            b.last = (len == 0);
            sb_q.push_back(b);
            base = NB;
        end else if (len == 0) begin
            b.data = '0;
            b.cnt  = '0;
            b.last = 1'b1;
            sb_q.push_back(b);
        end
        for (int k = 0; k < nblk; k++) begin
            int hi = ((k + 1) * NB < len) ? (k + 1) * NB : len;
            b.data = '0;
            for (int i = k * NB; i < hi; i++) b.data[8*(i - k*NB) +: 8] = msg[i];
            b.cnt  = CNT_W'(base + hi);
            b.last = (k == nblk - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic start_msg(input logic [6:0] klen);
        @(posedge clk); #1;
        start = 1'b1;
`ifdef BLOKE2B_PACKER_KEY_EN
        key_len = klen;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_value("din_ready_after_start", 256'(din_ready), 256'(1'b1));
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        din       = b;
        din_valid = 1'b1;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            if (din_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        check_value("din_accept", 256'(acc), 256'(1'b1));
    endtask

    task automatic send_bytes(input bq_t q);
        for (int i = 0; i < q.size(); i++) send_byte(q[i]);
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        @(negedge clk);
        check_value("finish_latency", 256'(blk_valid), 256'(1'b1));
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        check_value("drain", 256'(sb_q.size()), 256'(0));
    endtask

    // Consumer: drives blk_ready, checks hold stability under stall, pops scoreboard on handshake.
    initial begin
        int          wait_cyc = 0;
        bit          have_snap = 1'b0;
        blk_t        snap;
        blk_t        e;
        forever begin
            @(posedge clk); #1;
            if (blk_valid && bp_en && wait_cyc < 5) begin
                blk_ready = 1'b0;
                wait_cyc++;
            end else begin
                blk_ready = 1'b1;
            end
            @(negedge clk);
            if (blk_valid && blk_ready) begin
                check_value("sb_nonempty", 256'(sb_q.size() != 0), 256'(1'b1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_block("blk", e);
                end
                wait_cyc  = 0;
                have_snap = 1'b0;
            end else if (blk_valid) begin
                if (have_snap) begin
                    check_value("hold_data", 256'(blk_data == snap.data), 256'(1'b1));
                    check_value("hold_cnt", 256'(blk_cnt), 256'(snap.cnt));
                    check_value("hold_last", 256'(blk_last), 256'(snap.last));
                end
                check_value("stall_din_ready", 256'(din_ready), 256'(1'b0));
                snap.data = blk_data;
                snap.cnt  = blk_cnt;
                snap.last = blk_last;
                have_snap = 1'b1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t none;
        bq_t msg;
        bq_t key;
        none = {};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_din_ready", 256'(din_ready), 256'(1'b0));
        check_value("rst_blk_valid", 256'(blk_valid), 256'(1'b0));
        check_value("rst_blk_last", 256'(blk_last), 256'(1'b0));
        check_value("rst_blk_cnt", 256'(blk_cnt), 256'(0));
        check_value("rst_blk_data", 256'(blk_data == '0), 256'(1'b1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Empty message
        expect_msg(none, none);
        start_msg(7'd0);
        pulse_finish();
        wait_drain();

        // "abc"
        msg = {8'h61, 8'h62, 8'h63};
        expect_msg(none, msg);
        start_msg(7'd0);
        send_bytes(msg);
        pulse_finish();
        wait_drain();

        // Exactly one full block
        msg = {};
        for (int i = 0; i < NB; i++) msg.push_back(8'(i));
        expect_msg(none, msg);
        start_msg(7'd0);
        send_bytes(msg);
        pulse_finish();
        wait_drain();

        // 129 bytes, then again under backpressure
        msg.push_back(8'h80);
        for (int pass = 0; pass < 2; pass++) begin
            bp_en = (pass == 1);
            expect_msg(none, msg);
            start_msg(7'd0);
            send_bytes(msg);
            pulse_finish();
            wait_drain();
        end
        bp_en = 1'b0;

        // Abort after 50 bytes, restart with "123"
        msg = {};
        for (int i = 0; i < 50; i++) msg.push_back(8'($urandom_range(0, 255)));
        start_msg(7'd0);
        send_bytes(msg);
        msg = {8'h31, 8'h32, 8'h33};
        expect_msg(none, msg);
        start_msg(7'd0);
        send_bytes(msg);
        pulse_finish();
        wait_drain();

`ifdef BLOKE2B_PACKER_KEY_EN
        key = {8'h6b, 8'h6b, 8'h6b};
        msg = {8'h61, 8'h62, 8'h63};
        expect_msg(key, msg);
        start_msg(7'd3);
        send_bytes(key);
        send_bytes(msg);
        pulse_finish();
        wait_drain();

        expect_msg(key, none);
        start_msg(7'd3);
        send_bytes(key);
        pulse_finish();
        wait_drain();
`else
        key = {};
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bloke2b_block_packer.md
# bloke2b_block_packer

Upstream framing stage for the BLAKE2b compression core. Accepts the message as a byte stream with the same `start`/`finish`/`din`/`din_valid`/`din_ready` contract the hash wrapper presents to its users. Packs bytes little-endian into 16-word message blocks, zero-pads the tail and tracks the byte counter `t`. Holds each full block until it knows whether more data follows, so the final-block flag is always correct.

## Interface
- `W`, 64: word width in bits; block = 16 words = 2*W bytes (64 gives BLAKE2b, 32 gives BLAKE2s).
- `CNT_W`, 128: width of the byte counter `t` (2*W per algorithm).
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; clears state and begins a new message.
- `finish` in 1: one-cycle pulse; no bytes follow the current ones.
- `din` in 8: message byte.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: packer accepts `din` this cycle.
- `blk_data` out 16*W: packed block; byte i at bits [8*i +: 8].
- `blk_cnt` out CNT_W: total message bytes up to and including this block (padding excluded).
- `blk_last` out 1: block is final (BLAKE2 f0 flag).
- `blk_valid` out 1: block output valid.
- `blk_ready` in 1: consumer takes the block when `blk_valid && blk_ready`.
- `key_len` in 7: key length in bytes, 0..64. Only present with `BLOKE2B_PACKER_KEY_EN`.

## Operation
- Byte transfer: occurs when `din_valid && din_ready`. The byte is written to buffer position `idx`, then `idx++` and `cnt++` (`cnt` wraps modulo 2^CNT_W).
- States:
  - IDLE, reset state.
  - FILL: `din_ready`=1 while `idx` < 2W.
  - HOLD: buffer full, `din_ready`=0.
  - EMIT: `blk_valid`=1, `blk_last`=0.
  - EMIT_LAST: `blk_valid`=1, `blk_last`=1.
  - DONE.
- Transitions:
  - Any state + `start` → FILL. Clears buffer, `idx`, `cnt`, pending finish. `start` has priority over all inputs except `rst`.
  - FILL: `idx` reaches 2W → HOLD. Pending finish → EMIT_LAST.
  - HOLD: `din_valid` → EMIT (more data exists; the byte is not consumed). Pending finish → EMIT_LAST.
  - EMIT + handshake → FILL with buffer zeroed and `idx`=0.
  - EMIT_LAST + handshake → DONE.
  - DONE ignores `din`/`finish` until `start`.
- `finish` is latched as pending. A byte with `din_valid && din_ready` in the same cycle belongs to the message. `finish` in IDLE/DONE is ignored.
- Padding: unwritten bytes are zero (buffer cleared on `start` and after each EMIT).
- Empty message: FILL with `idx`=0 + finish → EMIT_LAST with all-zero data, `blk_cnt`=0.
- Exact multiple of 2W bytes: the last full block goes out with `blk_last`=1. No trailing empty block.

## Timing
- Reset values:
  - `din_ready`=0, `blk_valid`=0, `blk_last`=0.
  - `blk_data`=0, `blk_cnt`=0.
- `din_ready`=1 in the cycle after `start`.
- `din_ready` is a registered-state decode and never depends combinationally on `din_valid`.
- Finish latency: `finish` at cycle n (FILL, or HOLD) → `blk_valid`=1 at n+1.
- HOLD with `din_valid` at cycle n → `blk_valid`=1 at n+1. That byte is accepted no earlier than the cycle after the block handshake.
- `blk_data`, `blk_cnt`, `blk_last` are registered and stable while `blk_valid && !blk_ready`. `blk_valid` stays asserted until the handshake.
- `start` while `blk_valid` is high: `blk_valid`=0 next cycle; the block is discarded.

## Configuration
- `BLOKE2B_PACKER_KEY_EN` defined:
  - `key_len` port exists and is sampled on `start`.
  - If nonzero, the first `key_len` bytes on `din` form block 0. After the key bytes, that block is zero-padded and `cnt` is set to 2W.
  - Block 0 is emitted as EMIT if any message byte arrives, or as EMIT_LAST with `blk_cnt`=2W if `finish` comes first.
  - `key_len`=0 behaves as unkeyed.
- Macro undefined: no `key_len` port; all bytes are message bytes.

## Test plan
- Empty message: `start`, `finish` → one block with `blk_data`=0, `blk_cnt`=0, `blk_last`=1.
- "abc" (61 62 63) then `finish` → `blk_data[23:0]`=24'h636261, all other bits 0, `blk_cnt`=3, `blk_last`=1.
- 128 bytes 0x00..0x7F then `finish` → exactly one block: word0=64'h0706050403020100, `blk_cnt`=128, `blk_last`=1.
- 129 bytes → block 1 with `blk_cnt`=128, `blk_last`=0; then block 2 with `blk_data[7:0]`=8'h80, `blk_cnt`=129, `blk_last`=1.
- Backpressure and abort:
  - 129-byte message with `blk_ready` low for 5 cycles per block → outputs stable, `din_ready`=0, no byte lost or duplicated.
  - Then `start` after 50 bytes of a new message, followed by "123" + `finish` → `blk_data[23:0]`=24'h333231, `blk_cnt`=3.
- KEY_EN, `key_len`=3:
  - Key "kkk", message "abc" → block 0 with `blk_cnt`=128, `blk_last`=0; then block 1 with `blk_cnt`=131, `blk_last`=1.
  - Key only, then `finish` → one block with `blk_cnt`=128, `blk_last`=1.
